// File: rtl/carregador_programa.sv
// Program loader for the nRISC core: receives a length-prefixed, checksummed byte
// stream and writes it into instruction memory, holding the core in reset until it checks good.
module carregador_programa #(
    parameter logic [7:0] ADDR_BASE = 8'h00
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       cpu_reset,
    output logic       done,
    output logic       erro
);

    typedef enum logic [2:0] {
        OCIOSO,
        TAMANHO,
        DADOS,
        CHECKSUM,
        PRONTO,
        ERRO
    } state_t;

    state_t     state_q;
    logic [8:0] len_q;
    logic [8:0] cnt_q;
    logic [7:0] sum_q;
    logic       mem_we_q;
    logic [7:0] mem_addr_q;
    logic [7:0] mem_data_q;
    logic       cpu_reset_q;
    logic       done_q;
    logic       erro_q;
    logic       accept;

    // NOTE: byte_ready depends on state only, so the stream source never sees a
    // combinational path from its own byte_valid back to byte_ready.
    assign byte_ready = (state_q == TAMANHO) || (state_q == DADOS) || (state_q == CHECKSUM);
    assign accept     = byte_valid && byte_ready;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= OCIOSO;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_BASE;
            mem_data_q  <= '0;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                OCIOSO: begin
                    if (start) state_q <= TAMANHO;
                end
                TAMANHO: begin
                    if (accept) begin
                        // A length byte of zero encodes a full 256-byte program.
                        len_q   <= (byte_in == 8'h00) ? 9'd256 : {1'b0, byte_in};
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        state_q <= DADOS;
                    end
                end
                DADOS: begin
                    if (accept) begin
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= ADDR_BASE + cnt_q[7:0];
                        mem_data_q <= byte_in;
                        sum_q      <= sum_q + byte_in;
                        cnt_q      <= cnt_q + 9'd1;
                        if (cnt_q + 9'd1 == len_q) state_q <= CHECKSUM;
                    end
                end
                CHECKSUM: begin
                    if (accept) begin
                        if (byte_in == sum_q) begin
                            state_q     <= PRONTO;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b1;
                        end else begin
                            state_q <= ERRO;
                            erro_q  <= 1'b1;
                        end
                    end
                end
                PRONTO, ERRO: begin
                    if (start) begin
                        state_q     <= TAMANHO;
                        done_q      <= 1'b0;
                        erro_q      <= 1'b0;
                        cpu_reset_q <= 1'b0;
                    end
                end
                default: state_q <= OCIOSO;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign erro      = erro_q;

endmodule

// File: tb/tb_carregador_programa.sv
// Self-checking bench for carregador_programa: two instances (base 00 and FE) share one
// stimulus stream; writes are compared against a queue-based model of the stream rules.
module tb_carregador_programa;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;

    logic       rdy0, we0, cpur0, done0, erro0;
    logic [7:0] addr0, data0;
    logic       rdy1, we1, cpur1, done1, erro1;
    logic [7:0] addr1, data1;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    wr_t obs0[$];
    wr_t obs1[$];

    carregador_programa #(.ADDR_BASE(8'h00)) dut0 (
        .CLK(CLK), .RESET(RESET), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(rdy0), .mem_we(we0),
        .mem_addr(addr0), .mem_data(data0), .cpu_reset(cpur0),
        .done(done0), .erro(erro0)
    );

    carregador_programa #(.ADDR_BASE(8'hFE)) dut1 (
        .CLK(CLK), .RESET(RESET), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(rdy1), .mem_we(we1),
        .mem_addr(addr1), .mem_data(data1), .cpu_reset(cpur1),
        .done(done1), .erro(erro1)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Write monitor: records every strobe with the index of the edge that produced it.
    always @(negedge CLK) begin
        if (we0 === 1'b1) obs0.push_back('{addr0, data0, cyc});
        if (we1 === 1'b1) obs1.push_back('{addr1, data1, cyc});
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_status(input string tag, input logic exp_rdy, input logic exp_done,
                                input logic exp_erro, input logic exp_cpur);
        check({tag, ".rdy0"},  32'(rdy0),  32'(exp_rdy));
        check({tag, ".rdy1"},  32'(rdy1),  32'(exp_rdy));
        check({tag, ".done0"}, 32'(done0), 32'(exp_done));
        check({tag, ".done1"}, 32'(done1), 32'(exp_done));
        check({tag, ".erro0"}, 32'(erro0), 32'(exp_erro));
        check({tag, ".erro1"}, 32'(erro1), 32'(exp_erro));
        check({tag, ".cpur0"}, 32'(cpur0), 32'(exp_cpur));
        check({tag, ".cpur1"}, 32'(cpur1), 32'(exp_cpur));
    endtask

    task automatic check_reset_vals(input string tag);
        check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, ".we0"},   32'(we0),   32'h0);
        check({tag, ".we1"},   32'(we1),   32'h0);
        check({tag, ".addr0"}, 32'(addr0), 32'h00);
        check({tag, ".addr1"}, 32'(addr1), 32'hFE);
        check({tag, ".data0"}, 32'(data0), 32'h00);
        check({tag, ".data1"}, 32'(data1), 32'h00);
    endtask

    // Expected write i goes to (base + i) mod 256 on the edge that accepted program byte i.
    task automatic check_writes(input string tag, input wr_t got[$], input int base,
                                input logic [7:0] prog[$], input int acc[$]);
        check({tag, ".count"}, 32'(got.size()), 32'(prog.size()));
        for (int i = 0; i < prog.size() && i < got.size(); i++) begin
            check({tag, ".addr"}, 32'(got[i].addr), 32'((base + i) % 256));
            check({tag, ".data"}, 32'(got[i].data), 32'(prog[i]));
            check({tag, ".cyc"},  32'(got[i].cyc),  32'(acc[i]));
        end
    endtask

    // Drives one complete stream (L, program bytes, C) and checks the outcome.
    task automatic load(input string tag, input logic [7:0] stream[$], input bit gaps,
                        input bit start_mid);
        logic [7:0] prog[$];
        int         acc[$];
        int         sum;
        bit         good;
        prog = stream[1:$-1];
        sum  = 0;
        foreach (prog[i]) sum += int'(prog[i]);
        good = ((sum % 256) == int'(stream[stream.size()-1]));
        obs0.delete();
        obs1.delete();

        start = 1'b1;
        step();
        start = 1'b0;
        check_status({tag, ".entry"}, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < stream.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    byte_valid = 1'b0;
                    byte_in    = 8'($urandom);
                    step();
                    check({tag, ".gap_rdy0"}, 32'(rdy0), 32'h1);
                end
            end
            byte_valid = 1'b1;
            byte_in    = stream[i];
            if (start_mid && i == 2) start = 1'b1;
            step();
            start = 1'b0;
            if (i >= 1 && i <= stream.size() - 2) acc.push_back(cyc);
        end
        byte_valid = 1'b0;

        check_status({tag, ".end"}, 1'b0, good, !good, good);
        step();
        check_status({tag, ".hold"}, 1'b0, good, !good, good);
        check_writes({tag, ".w0"}, obs0, 32'h00, prog, acc);
        check_writes({tag, ".w1"}, obs1, 32'hFE, prog, acc);
    endtask

    initial begin
        logic [7:0] s[$];
        logic [7:0] p[$];
        int         len;
        int         sum;

        RESET      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        step();
        step();
        RESET = 1'b1;
        check_reset_vals("reset");
        step();
        check_status("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        load("basic", s, 1'b0, 1'b0);

        s = '{8'h02, 8'h10, 8'h20, 8'h31};
        load("badsum", s, 1'b0, 1'b0);

        s = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        load("wrap", s, 1'b0, 1'b0);

        s.delete();
        s.push_back(8'h00);
        for (int i = 0; i < 256; i++) s.push_back(8'(i));
        s.push_back(8'h80);
        load("full", s, 1'b0, 1'b0);

        s = '{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
        load("gaps", s, 1'b1, 1'b0);

        s = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A};
        load("start_mid", s, 1'b0, 1'b1);

        // Reset after the second program byte of a five-byte load.
        obs0.delete();
        obs1.delete();
        start = 1'b1;
        step();
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h05;
        step();
        byte_in = 8'h5A;
        step();
        byte_in = 8'hA5;
        step();
        byte_valid = 1'b0;
        RESET      = 1'b0;
        step();
        RESET = 1'b1;
        check_reset_vals("midreset");
        repeat (3) step();
        check("midreset.count0", 32'(obs0.size()), 32'd2);
        check("midreset.count1", 32'(obs1.size()), 32'd2);
        check_status("midreset.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        load("after_reset", s, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            len = int'($urandom_range(1, 40));
            p.delete();
            sum = 0;
            for (int i = 0; i < len; i++) begin
                p.push_back(8'($urandom));
                sum += int'(p[i]);
            end
            s.delete();
            s.push_back(8'(len));
            foreach (p[i]) s.push_back(p[i]);
            if ($urandom_range(0, 2) == 0) s.push_back(8'((sum + int'($urandom_range(1, 255))) % 256));
            else                           s.push_back(8'(sum % 256));
            load("random", s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Program loader for the nRISC core. Receives a length-prefixed, checksummed byte stream over a valid/ready handshake and writes it into instruction memory starting at a base address. Holds the core in reset while loading and releases it only after a correct checksum. It is the write side of the instruction memory, which the core only reads.

## Interface
- `ADDR_BASE`, default 8'h00: instruction memory address of the first program byte.
- `CLK`  in  1  system clock; all state updates on rising edge.
- `RESET`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in OCIOSO, PRONTO, ERRO.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction memory write strobe, one cycle per byte.
- `mem_addr`  out  8  write address.
- `mem_data`  out  8  write data.
- `cpu_reset`  out  1  active-low reset to the core; 0 holds the core.
- `done`  out  1  level; load completed with a good checksum.
- `erro`  out  1  level; checksum mismatch on the last load.

## Operation
- Stream format: length byte L, then N program bytes, then checksum byte C. N = L for L = 1..255; N = 256 for L = 0. C must equal the sum of the N program bytes mod 256.
- Transfer: a byte is accepted on a rising edge where `byte_valid` and `byte_ready` are both 1. `byte_ready` is a combinational function of state only, and never depends on `byte_valid`.
- States:
  - OCIOSO: `byte_ready`=0. `start` goes to TAMANHO.
  - TAMANHO: `byte_ready`=1. On accept, latch N, clear the counter and the running sum, go to DADOS.
  - DADOS: `byte_ready`=1. On accept, register the memory write, add the byte to the sum, increment the counter. After the Nth accept, go to CHECKSUM.
  - CHECKSUM: `byte_ready`=1. On accept, compare with the sum. Equal goes to PRONTO; unequal goes to ERRO.
  - PRONTO: `done`=1, `cpu_reset`=1. `start` goes to TAMANHO.
  - ERRO: `erro`=1, `cpu_reset`=0. `start` goes to TAMANHO.
- `cpu_reset` is 0 in every state except PRONTO. Entering TAMANHO from PRONTO re-asserts the core reset on the next edge.
- Address arithmetic: `mem_addr` = ADDR_BASE + index, 8-bit, wrapping modulo 256. With N=256 every location is written exactly once.
- Running sum is 8 bits and wraps. The byte counter is 9 bits, so N=256 is representable.
- `done` and `erro` are never both 1. Both clear on the edge that leaves PRONTO/ERRO.
- `start` asserted in TAMANHO, DADOS or CHECKSUM is ignored. It neither restarts nor aborts the load.
- Memory contents written before an ERRO are not rolled back. The core stays in reset, so they are harmless.

## Timing
- Reset (`RESET`=0 at an edge) puts all outputs in the following state on the next cycle:
  - state OCIOSO;
  - `byte_ready`=0, `mem_we`=0, `mem_addr`=ADDR_BASE, `mem_data`=0;
  - `cpu_reset`=0, `done`=0, `erro`=0.
- Reset takes priority over every other input, including mid-load. The next `start` begins a fresh load.
- Write latency is 1 cycle. A program byte accepted at edge k appears on `mem_we`=1, `mem_addr`, `mem_data` during cycle k to k+1 only.
- `mem_addr` and `mem_data` hold their last values while `mem_we`=0.
- Back-to-back: with `byte_valid` held at 1, one byte is accepted per cycle. The loader never stalls the stream.
- Gaps: `byte_valid`=0 in any receiving state holds the state and counters unchanged. There is no timeout.
- Load duration with a continuous stream: N+2 accept cycles after entering TAMANHO.
- The final program byte's write (cycle after the Nth accept) overlaps the CHECKSUM state. `done` rises on the edge that accepts C, at the earliest one cycle after the last `mem_we`.
- `cpu_reset` goes to 1 on the same edge that `done` goes to 1.

## Test plan
- Basic load, ADDR_BASE=0: stream 03, 11, 22, 33, 66 back-to-back.
  - Writes (00,11), (01,22), (02,33) on consecutive cycles.
  - Then `done`=1, `cpu_reset`=1, `erro`=0.
- Bad checksum: stream 02, 10, 20, 31.
  - Writes (00,10), (01,20).
  - Then `erro`=1, `done`=0, `cpu_reset`=0.
  - `start` then re-enters TAMANHO with `erro`=0.
- Wrap, ADDR_BASE=8'hFE: stream 04, 01, 02, 03, 04, 0A.
  - Writes at addresses FE, FF, 00, 01.
  - Ends with `done`=1.
- Full length: L=00, 256 bytes of value i at position i, C=80 (sum 0..255 mod 256).
  - Exactly 256 writes, every address once.
  - Ends with `done`=1.
- Handshake gaps: 03, AA, BB, CC, 31 with `byte_valid` toggling 1,0,0,1,...
  - `byte_ready` stays 1 throughout.
  - Only valid cycles are counted.
  - Writes unchanged versus the back-to-back case.
  - Ends with `done`=1.
- Reset mid-load: `RESET`=0 after the second program byte.
  - Next cycle: OCIOSO, all outputs at reset values, no further `mem_we`.
  - A new full load then succeeds.
  - `start` pulsed mid-DADOS is ignored.
